// File: rtl/result_stream.sv
// result_stream: buffers MAC result words in a small FIFO and serializes each word MSB byte first.
// Latency: a word pushed into an empty FIFO with the serializer idle shows its first byte two cycles later.
// Backpressure: none on either side; a result that finds the FIFO full (and no pop) is dropped and sets overflow_o.
//
// Ports:
//   clk, rst        - sole clock, synchronous active-high reset
//   ena             - global enable; low freezes every register
//   result_v_i/_i   - single-cycle MAC result word strobe and data
//   data_v_o/_o     - registered output byte and its valid
//   last_o          - registered marker on the final byte of a word
//   level_o         - FIFO occupancy, 0..DEPTH
//   overflow_o      - sticky dropped-result flag, cleared only by rst
module result_stream #(
  parameter int W     = 16,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     result_v_i,
  input  logic [W-1:0]             result_i,
  output logic                     data_v_o,
  output logic [OUT_W-1:0]         data_o,
  output logic                     last_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int NB = W / OUT_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [LW-1:0] FULL   = LW'(DEPTH);
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // FIFO storage and bookkeeping
  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [LW-1:0]   r_level;
  logic            r_ovf;

  // Serializer state and registered outputs
  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [W-1:0]    r_sh;
  logic [OUT_W-1:0] r_data;
  logic            r_v;
  logic            r_last;

  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [W-1:0]    w_head;
  logic [LW-1:0]   w_level_nx;
  state_t          w_state_nx;
  logic [KW-1:0]   w_k_nx;
  logic [W-1:0]    w_sh_nx;
  logic [OUT_W-1:0] w_data_nx;
  logic            w_v_nx;
  logic            w_last_nx;

  assign w_head = r_mem[r_rp];

  // A pop only happens with a word actually stored, so an empty FIFO never
  // forwards an incoming word straight to the serializer. A pop frees a slot
  // in the same cycle, which lets a push into a full FIFO succeed.
  always_comb begin
    w_pop      = ena && (r_level != '0) && ((r_state == IDLE) || (r_k == K_LAST));
    w_push     = ena && result_v_i && ((r_level != FULL) || w_pop);
    w_drop     = ena && result_v_i && !w_push;
    w_level_nx = r_level + LW'(w_push) - LW'(w_pop);
  end

  // Serializer next-state and output logic. The shift register holds the
  // not-yet-emitted bytes left-aligned, so the next byte is always its top slice.
  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_sh_nx    = r_sh;
    w_data_nx  = r_data;
    w_v_nx     = r_v;
    w_last_nx  = r_last;
    if (ena) begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            w_state_nx = SHIFT;
            w_k_nx     = '0;
            w_data_nx  = w_head[W-1 -: OUT_W];
            w_sh_nx    = w_head << OUT_W;
            w_v_nx     = 1'b1;
            w_last_nx  = (K_LAST == '0);
          end
        end
        SHIFT: begin
          if (r_k != K_LAST) begin
            w_k_nx    = r_k + 1'b1;
            w_data_nx = r_sh[W-1 -: OUT_W];
            w_sh_nx   = r_sh << OUT_W;
            w_v_nx    = 1'b1;
            w_last_nx = ((r_k + 1'b1) == K_LAST);
          end else if (w_pop) begin
            // Chain straight into the next word: no gap cycle.
            w_k_nx    = '0;
            w_data_nx = w_head[W-1 -: OUT_W];
            w_sh_nx   = w_head << OUT_W;
            w_v_nx    = 1'b1;
            w_last_nx = (K_LAST == '0);
          end else begin
            // data_o keeps its last value while idle.
            w_state_nx = IDLE;
            w_k_nx     = '0;
            w_v_nx     = 1'b0;
            w_last_nx  = 1'b0;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_v_nx     = 1'b0;
          w_last_nx  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_state <= IDLE;
      r_k     <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_v     <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_drop) r_ovf <= 1'b1;
      r_level <= w_level_nx;
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
      r_sh    <= w_sh_nx;
      r_data  <= w_data_nx;
      r_v     <= w_v_nx;
      r_last  <= w_last_nx;
    end
  end

  // Storage is not reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wp] <= result_i;
  end

  assign data_v_o   = r_v;
  assign data_o     = r_data;
  assign last_o     = r_last;
  assign level_o    = r_level;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_result_stream.sv
// tb_result_stream: drives directed and randomized result words into result_stream
// and checks every output cycle against a queue-based reference model through a scoreboard.
module tb_result_stream;

  localparam int W     = 16;
  localparam int OUT_W = 8;
  localparam int DEPTH = 4;
  localparam int NB    = W / OUT_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ena;
  logic                   result_v_i;
  logic [W-1:0]           result_i;
  logic                   data_v_o;
  logic [OUT_W-1:0]       data_o;
  logic                   last_o;
  logic [$clog2(DEPTH):0] level_o;
  logic                   overflow_o;

  always #5 clk = ~clk;

  result_stream #(.W(W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .result_v_i (result_v_i),
    .result_i   (result_i),
    .data_v_o   (data_v_o),
    .data_o     (data_o),
    .last_o     (last_o),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  int ncmp = 0;
  int nerr = 0;
  bit started = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the word being shown.
  logic [W-1:0]     m_q[$];
  logic [OUT_W:0]   exp_q[$];   // {last, byte} expected beats, in order
  bit               m_show = 0;
  int               m_rem  = 0; // beats still to show after the current one
  int               m_idx  = 0;
  logic [W-1:0]     m_cur  = '0;
  logic [OUT_W-1:0] m_hold = '0;
  bit               m_ovf  = 0;
  bit               m_fresh = 0;

  always @(posedge clk) begin
    bit pop;
    bit acc;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_show  = 0;
      m_rem   = 0;
      m_hold  = '0;
      m_ovf   = 0;
      m_fresh = 0;
    end else if (ena) begin
      pop = (m_q.size() > 0) && (!m_show || m_rem == 0);
      acc = result_v_i && ((m_q.size() < DEPTH) || pop);
      if (m_show && m_rem > 0) begin
        m_rem--;
        m_idx++;
      end else if (pop) begin
        m_cur  = m_q.pop_front();
        m_idx  = 0;
        m_rem  = NB - 1;
        m_show = 1;
        for (int i = 0; i < NB; i++)
          exp_q.push_back({(i == NB - 1) ? 1'b1 : 1'b0, m_cur[W-1-i*OUT_W -: OUT_W]});
      end else begin
        m_show = 0;
      end
      if (m_show) m_hold = m_cur[W-1-m_idx*OUT_W -: OUT_W];
      if (acc) m_q.push_back(result_i);
      else if (result_v_i) m_ovf = 1;
      m_fresh = 1;
    end else begin
      m_fresh = 0;
    end
  end

  // Monitor: samples away from the active edge and pops the scoreboard on each new beat.
  always @(negedge clk) begin
    logic [OUT_W:0] e;
    if (started) begin
      check("valid", 32'(data_v_o), 32'(m_show));
      check("level", 32'(level_o), m_q.size());
      check("overflow", 32'(overflow_o), 32'(m_ovf));
      check("data_value", 32'(data_o), 32'(m_hold));
      if (!data_v_o) begin
        check("last_idle", 32'(last_o), 32'd0);
      end else if (m_fresh) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(data_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(data_o), 32'(e[OUT_W-1:0]));
          check("beat_last", 32'(last_o), 32'(e[OUT_W]));
        end
      end
    end
  end

  task automatic cyc(input bit e, input bit r, input bit v, input logic [W-1:0] d);
    ena        = e;
    rst        = r;
    result_v_i = v;
    result_i   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, '0);
  endtask

  initial begin
    int rate;
    logic [W-1:0] rw;
    cyc(0, 1, 1, 16'hDEAD);
    started = 1;
    cyc(1, 1, 0, '0);

    // Single word
    cyc(1, 0, 1, 16'hBEEF);
    idle(5);

    // Back-to-back words
    cyc(1, 0, 1, 16'h1234);
    cyc(1, 0, 1, 16'h5678);
    idle(6);

    // Continuous burst: fills the FIFO, accepts a push while full on a final-beat pop, then drops
    for (int i = 1; i <= 12; i++) cyc(1, 0, 1, 16'(i));
    idle(20);
    cyc(1, 1, 0, '0);

    // Enable stall between the two bytes of a word; strobes while stalled are ignored
    cyc(1, 0, 1, 16'hA55A);
    cyc(1, 0, 0, '0);
    cyc(0, 0, 1, 16'h1111);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 1, 16'h2222);
    idle(5);

    // Reset mid-word with more words queued, a strobe coincident with reset, then one fresh word
    cyc(1, 0, 1, 16'hCAFE);
    cyc(1, 0, 1, 16'h3333);
    cyc(1, 0, 1, 16'h4444);
    cyc(1, 1, 1, 16'h5555);
    idle(2);
    cyc(1, 0, 1, 16'h0F0F);
    idle(6);

    // Randomized traffic with varying offered load, stalls and occasional resets
    for (int blk = 0; blk < 8; blk++) begin
      rate = (blk % 3 == 0) ? 30 : ((blk % 3 == 1) ? 55 : 90);
      for (int i = 0; i < 100; i++) begin
        rw = W'($urandom);
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 99) < rate, rw);
      end
    end

    idle(25);
    check("drain_beats_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/result_stream.md
RESULT_STREAM -- requirements
Module: result_stream

Interface
REQ-001 Parameter W, default 16: width of one MAC result word; SHALL be a multiple of OUT_W.
REQ-002 Parameter OUT_W, default 8: width of the output byte lane.
REQ-003 Parameter DEPTH, default 4: result FIFO depth in words; SHALL be a power of two, 2 or more.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ena  in  1  global enable; low SHALL freeze all state.
REQ-007 result_v_i  in  1  MAC result valid, single-cycle pulse per word; there is no backpressure.
REQ-008 result_i  in  W  MAC result word, sampled only when result_v_i=1.
REQ-009 data_v_o  out  1  output byte valid, registered.
REQ-010 data_o  out  OUT_W  output byte, registered.
REQ-011 last_o  out  1  high with the final byte of a word, registered.
REQ-012 level_o  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-013 overflow_o  out  1  sticky flag: a result was dropped.

Function
REQ-014 The FIFO SHALL accept a push when ena=1, result_v_i=1, and either level<DEPTH or a pop occurs in the same cycle.
REQ-015 A push that is not accepted SHALL drop the word, set overflow_o=1, and leave FIFO contents unchanged.
REQ-016 overflow_o SHALL clear only on rst.
REQ-017 Read and write pointers SHALL wrap modulo DEPTH.
REQ-018 level_o SHALL change by +1 on a push only, by -1 on a pop only, and by 0 on push+pop or when idle.
REQ-019 The serializer FSM SHALL have states IDLE and SHIFT, with a beat counter k = 0..W/OUT_W-1.
REQ-020 IDLE: when ena=1 and level>0, the FSM SHALL pop the head word into the shift register and go to SHIFT with k=0.
REQ-021 SHIFT: the FSM SHALL drive data_o = word[W-1-k*OUT_W -: OUT_W] (MSB byte first) and data_v_o=1, then increment k.
REQ-022 When k=W/OUT_W-1, last_o SHALL be 1.
REQ-023 After the final beat, the FSM SHALL pop again and stay in SHIFT with k=0 if level>0, otherwise go to IDLE; there SHALL be no gap cycle between back-to-back words.
REQ-024 data_v_o and last_o SHALL be 0 in any cycle without a beat.
REQ-025 data_o SHALL hold its last value when data_v_o=0.
REQ-026 Latency: a word pushed in cycle N with FIFO empty and FSM IDLE SHALL appear as its first byte in cycle N+2.
REQ-027 Sustained throughput SHALL be one word per W/OUT_W cycles; input arriving faster fills the FIFO and then sets overflow.
REQ-028 When ena=0, no push, pop, FSM transition or output register update SHALL occur; outputs SHALL hold their values.
REQ-029 When the FIFO is empty, a simultaneous push and pop request SHALL NOT bypass the FIFO; the word takes the normal REQ-026 path.

Reset
REQ-030 When rst=1 at a clock edge, regardless of ena, the block SHALL clear: pointers=0, level_o=0, FSM=IDLE, k=0, data_v_o=0, last_o=0, data_o=0, overflow_o=0.
REQ-031 A word partially shifted when rst is asserted SHALL be discarded; after reset no byte of that word, and no stale FIFO entry, SHALL appear.
REQ-032 result_v_i asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-033 Single word: push 0xBEEF at cycle 0 -> cycle 2 data_o=0xBE, v=1, last=0; cycle 3 data_o=0xEF, v=1, last=1; cycle 4 v=0, level_o=0.
REQ-034 Back-to-back: pushes 0x1234 and 0x5678 on consecutive cycles -> bytes 12,34,56,78 on cycles 2..5 with no gap; last_o=1 on cycles 3 and 5.
REQ-035 Overflow: push 8 words 0x0001..0x0008 on consecutive cycles with DEPTH=4 -> overflow_o rises, level_o never exceeds 4, output sequence is an in-order subset starting 0x0001 with no corruption; overflow_o stays 1 until rst.
REQ-036 Full with pop: FIFO full and FSM on the final beat while result_v_i=1 -> word accepted, level_o stays 4, overflow_o stays 0.
REQ-037 Enable stall: ena=0 for 3 cycles between the two bytes of 0xA55A -> data_o=0xA5 held with data_v_o=1 while stalled, then 0x5A follows the cycle after ena returns; level_o unchanged during the stall.
REQ-038 Mid-word reset: assert rst on the cycle 0xCAFE outputs 0xCA with 2 more words queued -> the next cycle all outputs are 0 and level_o=0; a subsequent push of 0x0F0F emits 0x0F, 0x0F only.
